// File: rtl/dmem_responder.sv
// dmem_responder
//
// Responder end of the core-to-data-memory interface for the dual-lane MIPS
// core. Two independent request lanes (a and b) share one single-ported word
// array through a request/grant/response handshake, so that each lane's
// memory stage can stall while the other lane holds the array.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous, active-high reset
//   x_req               lane request, held with stable fields until x_gnt
//   x_we                1 = write, 0 = read
//   x_addr              byte address; word index is addr[DEPTH_LOG2+1:2]
//   x_wdata             write data
//   x_gnt               request accepted this cycle (combinational)
//   x_rvalid            one-cycle response pulse, the cycle after x_gnt
//   x_rdata             response data (registered)
//   x_err               misaligned-access flag, qualified by x_rvalid
//   (x is a or b)
//
// Timing summary
//   - An uncontended request is granted in the cycle it is raised.
//   - The response follows exactly one cycle after the grant cycle.
//   - A write acknowledges with its own write data (write-first).
//   - A misaligned access is granted, writes nothing, and responds with
//     rdata = 0, err = 1.

module dmem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             a_req,
  input  logic             a_we,
  input  logic [WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  output logic             a_err,

  input  logic             b_req,
  input  logic             b_we,
  input  logic [WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] b_rdata,
  output logic             b_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Priority pointer: names the lane that wins the next contended,
  // non-broadcast cycle.
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t prio_reg;
  prio_t prio_next;

  logic [WIDTH-1:0] mem_reg [DEPTH];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [DEPTH_LOG2-1:0] a_idx;
  logic [DEPTH_LOG2-1:0] b_idx;
  logic                  a_mis;
  logic                  b_mis;
  logic                  contend;
  logic                  bcast;

  // Address bits above the word index are deliberately ignored, which makes
  // the array alias modulo 4*DEPTH bytes.
  assign a_idx = a_addr[DEPTH_LOG2+1:2];
  assign b_idx = b_addr[DEPTH_LOG2+1:2];
  assign a_mis = |a_addr[1:0];
  assign b_mis = |b_addr[1:0];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{a_addr[WIDTH-1:DEPTH_LOG2+2],
                              b_addr[WIDTH-1:DEPTH_LOG2+2]};

  assign contend = a_req & b_req;

  // Two aligned reads of the same word can be served by one array read, so
  // both lanes are granted together and the pointer is left alone.
  assign bcast = contend & ~a_we & ~b_we & ~a_mis & ~b_mis & (a_idx == b_idx);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    prio_next = prio_reg;
    if (!rst) begin
      if (contend && !bcast) begin
        // Contended single grant: the pointer lane wins, then the pointer
        // moves to the loser so it is served next cycle.
        if (prio_reg == PRIO_A) begin
          a_gnt     = 1'b1;
          prio_next = PRIO_B;
        end else begin
          b_gnt     = 1'b1;
          prio_next = PRIO_A;
        end
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write port select
  // ---------------------------------------------------------------------------
  // Both lanes are only ever granted together for a broadcast read, so at most
  // one of these write terms can be true in any cycle.
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [WIDTH-1:0]      wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (a_gnt && a_we && !a_mis) begin
      wr_en   = 1'b1;
      wr_idx  = a_idx;
      wr_data = a_wdata;
    end else if (b_gnt && b_we && !b_mis) begin
      wr_en   = 1'b1;
      wr_idx  = b_idx;
      wr_data = b_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Response data
  // ---------------------------------------------------------------------------
  // Reads sample the array before this edge's write lands; a same-word
  // read/write pair can never be granted together, so no bypass is needed.
  logic [WIDTH-1:0] a_resp_data;
  logic [WIDTH-1:0] b_resp_data;

  always_comb begin
    if (a_mis) begin
      a_resp_data = '0;
    end else if (a_we) begin
      a_resp_data = a_wdata;
    end else begin
      a_resp_data = mem_reg[a_idx];
    end

    if (b_mis) begin
      b_resp_data = '0;
    end else if (b_we) begin
      b_resp_data = b_wdata;
    end else begin
      b_resp_data = mem_reg[b_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      prio_reg <= PRIO_A;
      a_rvalid <= 1'b0;
      a_err    <= 1'b0;
      a_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_err    <= 1'b0;
      b_rdata  <= '0;
    end else begin
      prio_reg <= prio_next;

      if (wr_en) begin
        mem_reg[wr_idx] <= wr_data;
      end

      a_rvalid <= a_gnt;
      a_err    <= a_gnt & a_mis;
      if (a_gnt) begin
        a_rdata <= a_resp_data;
      end

      b_rvalid <= b_gnt;
      b_err    <= b_gnt & b_mis;
      if (b_gnt) begin
        b_rdata <= b_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios followed by randomized
// two-lane traffic, checked against a behavioural memory/arbitration model.

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(6), .WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .a_err    (a_err),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .b_err    (b_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: 64-word memory and a priority flag (0 = lane a).
  logic [31:0] mem_m [64];
  logic        prio_m;
  logic        exp_a_rv, exp_b_rv, exp_a_er, exp_b_er;
  logic [31:0] exp_a_rd, exp_b_rd;
  logic        last_ga, last_gb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 32'd4) % 32'd64);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    base = ($urandom_range(0, 3) * 32'h100) + ($urandom_range(0, 7) * 32'd4);
    if ($urandom_range(0, 7) == 0) base = base + $urandom_range(1, 3);
    return base;
  endfunction

  // One clock cycle: drive both lanes at the falling edge, check grants,
  // advance the model, then check the responses after the rising edge.
  task automatic step(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                      input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
    logic ga, gb, ma, mb, bc;
    int   ia, ib;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    ia = word_of(aa);
    ib = word_of(ba);
    ma = (aa % 4) != 0;
    mb = (ba % 4) != 0;
    bc = ar && br && !aw && !bw && !ma && !mb && (ia == ib);
    if (ar && br && !bc) begin
      ga     = (prio_m == 1'b0);
      gb     = (prio_m == 1'b1);
      prio_m = ~prio_m;
    end else begin
      ga = ar;
      gb = br;
    end
    check("a_gnt", a_gnt, ga);
    check("b_gnt", b_gnt, gb);

    exp_a_rv = ga;
    exp_b_rv = gb;
    exp_a_er = ma;
    exp_b_er = mb;
    exp_a_rd = ma ? 32'd0 : (aw ? ad : mem_m[ia]);
    exp_b_rd = mb ? 32'd0 : (bw ? bd : mem_m[ib]);
    if (ga && aw && !ma) mem_m[ia] = ad;
    if (gb && bw && !mb) mem_m[ib] = bd;
    last_ga = ga;
    last_gb = gb;

    @(posedge clk);
    @(negedge clk);
    check("a_rvalid", a_rvalid, exp_a_rv);
    check("b_rvalid", b_rvalid, exp_b_rv);
    if (exp_a_rv) begin
      check("a_rdata", a_rdata, exp_a_rd);
      check("a_err", a_err, exp_a_er);
    end
    if (exp_b_rv) begin
      check("b_rdata", b_rdata, exp_b_rd);
      check("b_err", b_err, exp_b_er);
    end
    $display("txn t=%0t a(req=%0b we=%0b addr=%h gnt=%0b) b(req=%0b we=%0b addr=%h gnt=%0b) a_rd=%h b_rd=%h",
             $time, ar, aw, aa, ga, br, bw, ba, gb, a_rdata, b_rdata);
  endtask

  // Reset for one edge while leaving lane inputs as they are.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst a_gnt", a_gnt, 1'b0);
    check("rst b_gnt", b_gnt, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("rst a_rvalid", a_rvalid, 1'b0);
    check("rst b_rvalid", b_rvalid, 1'b0);
    check("rst a_err", a_err, 1'b0);
    check("rst b_err", b_err, 1'b0);
    check("rst a_rdata", a_rdata, 32'd0);
    check("rst b_rdata", b_rdata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) mem_m[i] = 32'd0;
    prio_m = 1'b0;
    $display("txn t=%0t reset", $time);
  endtask

  logic        ra_act, ra_we, rb_act, rb_we;
  logic [31:0] ra_addr, ra_wd, rb_addr, rb_wd;

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    @(negedge clk);
    do_reset();

    // Write then cross-lane read.
    step(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    check("t1 a_rdata", a_rdata, 32'hDEADBEEF);
    step(0, 0, 0, 0, 1, 0, 32'h10, 0);
    check("t1 b_rdata", b_rdata, 32'hDEADBEEF);

    // Simultaneous writes from reset: a first, b the following cycle.
    do_reset();
    step(1, 1, 32'h20, 32'd1, 1, 1, 32'h24, 32'd2);
    check("t2 first a_gnt", last_ga, 1'b1);
    step(0, 0, 0, 0, 1, 1, 32'h24, 32'd2);
    check("t2 second b_gnt", last_gb, 1'b1);
    step(1, 0, 32'h20, 0, 0, 0, 0, 0);
    check("t2 read 0x20", a_rdata, 32'd1);
    step(0, 0, 0, 0, 1, 0, 32'h24, 0);
    check("t2 read 0x24", b_rdata, 32'd2);

    // Broadcast read.
    step(1, 1, 32'h10, 32'h12345678, 0, 0, 0, 0);
    step(1, 0, 32'h10, 0, 1, 0, 32'h10, 0);
    check("t3 both granted", {last_ga, last_gb}, 2'b11);
    check("t3 a_rdata", a_rdata, 32'h12345678);
    check("t3 b_rdata", b_rdata, 32'h12345678);

    // Address aliasing.
    step(1, 1, 32'h104, 32'hCAFEF00D, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h4, 0);
    check("t4 alias b_rdata", b_rdata, 32'hCAFEF00D);

    // Misaligned accesses write nothing.
    step(0, 0, 0, 0, 1, 0, 32'h13, 0);
    check("t5 b_err", b_err, 1'b1);
    check("t5 b_rdata", b_rdata, 32'd0);
    step(1, 1, 32'h11, 32'hFFFFFFFF, 0, 0, 0, 0);
    check("t5 a_err", a_err, 1'b1);
    step(1, 0, 32'h10, 0, 0, 0, 0, 0);
    check("t5 word intact", a_rdata, 32'h12345678);

    // Reset right after a grant, with the request still held.
    step(1, 0, 32'h10, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 0, 32'h10, 0, 0, 0, 0, 0);
    check("t6 cleared", a_rdata, 32'd0);

    // Randomized traffic; requests are held until the model grants them.
    ra_act = 1'b0; rb_act = 1'b0;
    ra_we = 1'b0; rb_we = 1'b0; ra_addr = '0; rb_addr = '0; ra_wd = '0; rb_wd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!ra_act && $urandom_range(0, 3) != 0) begin
        ra_act = 1'b1; ra_we = $urandom_range(0, 1) == 1; ra_addr = rand_addr(); ra_wd = $urandom;
      end
      if (!rb_act && $urandom_range(0, 3) != 0) begin
        rb_act = 1'b1; rb_we = $urandom_range(0, 1) == 1; rb_addr = rand_addr(); rb_wd = $urandom;
      end
      if (i == 300) do_reset();
      step(ra_act, ra_we, ra_addr, ra_wd, rb_act, rb_we, rb_addr, rb_wd);
      if (last_ga) ra_act = 1'b0;
      if (last_gb) rb_act = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
